// File: rtl/pcm_pkg.sv
// Shared types and constants for the ADPCM sample-ROM arbiter.
package pcm_pkg;

  localparam int unsigned PCM_ADDR_W           = 24;
  localparam int unsigned PCM_DATA_W           = 8;
  localparam int unsigned PCM_ROM_WAIT_DEFAULT = 2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } pcm_state_t;

endpackage

// File: rtl/pcm_arbiter_rr.sv
// Two-way grant decision for the ADPCM-A/B ROM ports.
// PCM_ARB_PRIO_B_EN: fixed ADPCM-B priority on ties instead of round-robin.
module pcm_rr_arb
  import pcm_pkg::*;
(
  input  logic CLK_68KCLKB,
  input  logic nRESET,
  input  logic grant_en,
  input  logic req_a,
  input  logic req_b,
  output logic grant,
  output logic grant_port
);

  logic last_grant;

  assign grant = grant_en & (req_a | req_b);

`ifdef PCM_ARB_PRIO_B_EN
  always_comb begin
    grant_port = req_b ? PORT_B : PORT_A;
  end
`else
  always_comb begin
    grant_port = req_b ? PORT_B : PORT_A;
    if (req_a && req_b) begin
      grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end
  end
`endif

  // Reset to B so that A wins the first tie.
  always_ff @(posedge CLK_68KCLKB) begin
    if (!nRESET) begin
      last_grant <= PORT_B;
    end else if (grant) begin
      last_grant <= grant_port;
    end
  end

endmodule

// File: rtl/pcm_arbiter.sv
// Shares one sample ROM between the ADPCM-A and ADPCM-B read ports.
// Optional macro PCM_ARB_PRIO_B_EN selects fixed B priority in pcm_rr_arb.
module pcm_arbiter
  import pcm_pkg::*;
#(
  parameter int unsigned ROM_WAIT = PCM_ROM_WAIT_DEFAULT
) (
  input  logic                  CLK_68KCLKB,
  input  logic                  nRESET,
  input  logic                  RREQ,
  input  logic [PCM_ADDR_W-1:0] RADDR,
  output logic                  RACK,
  output logic [PCM_DATA_W-1:0] RDATA,
  input  logic                  PREQ,
  input  logic [PCM_ADDR_W-1:0] PADDR,
  output logic                  PACK,
  output logic [PCM_DATA_W-1:0] PDATA,
  output logic [PCM_ADDR_W-1:0] ROM_A,
  output logic                  ROM_nOE,
  input  logic [PCM_DATA_W-1:0] ROM_D,
  output logic                  BUSY
);

  localparam logic [2:0] CNT_LOAD = 3'(ROM_WAIT - 1);

  pcm_state_t state;
  logic [2:0] cnt;
  logic       cur_port;
  logic       grant;
  logic       grant_port;

  pcm_rr_arb u_rr_arb (
    .CLK_68KCLKB (CLK_68KCLKB),
    .nRESET      (nRESET),
    .grant_en    (state == ST_IDLE),
    .req_a       (RREQ),
    .req_b       (PREQ),
    .grant       (grant),
    .grant_port  (grant_port)
  );

  always_ff @(posedge CLK_68KCLKB) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_port <= PORT_A;
      ROM_A    <= '0;
      ROM_nOE  <= 1'b1;
      RACK     <= 1'b0;
      PACK     <= 1'b0;
      RDATA    <= '0;
      PDATA    <= '0;
      BUSY     <= 1'b0;
    end else begin
      RACK <= 1'b0;
      PACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            ROM_A    <= (grant_port == PORT_B) ? PADDR : RADDR;
            cur_port <= grant_port;
            ROM_nOE  <= 1'b0;
            cnt      <= CNT_LOAD;
            BUSY     <= 1'b1;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (cur_port == PORT_B) begin
              PDATA <= ROM_D;
              PACK  <= 1'b1;
            end else begin
              RDATA <= ROM_D;
              RACK  <= 1'b1;
            end
            ROM_nOE <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_DONE: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          BUSY    <= 1'b0;
          ROM_nOE <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_arbiter.sv
// Scoreboard bench for pcm_arbiter: four instances with ROM_WAIT 2, 3, 1 and 7.
module tb_pcm_arbiter;
  import pcm_pkg::*;

  typedef struct {
    int         inst;
    logic       port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        rreq [4];
  logic        preq [4];
  logic [23:0] raddr [4];
  logic [23:0] paddr [4];
  logic        rack [4];
  logic        pack [4];
  logic [7:0]  rdata [4];
  logic [7:0]  pdata [4];
  logic [23:0] rom_a [4];
  logic        rom_noe [4];
  logic [7:0]  rom_d [4];
  logic        busy [4];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  logic [23:0] prev_a [4];
  logic        prev_noe [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD5;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) rom_d[i] = rom_noe[i] ? 8'hFF : rom_fn(rom_a[i]);
  end

  pcm_arbiter #(.ROM_WAIT(2)) u_dut0 (
    .CLK_68KCLKB(clk), .nRESET(nreset),
    .RREQ(rreq[0]), .RADDR(raddr[0]), .RACK(rack[0]), .RDATA(rdata[0]),
    .PREQ(preq[0]), .PADDR(paddr[0]), .PACK(pack[0]), .PDATA(pdata[0]),
    .ROM_A(rom_a[0]), .ROM_nOE(rom_noe[0]), .ROM_D(rom_d[0]), .BUSY(busy[0]));
  pcm_arbiter #(.ROM_WAIT(3)) u_dut1 (
    .CLK_68KCLKB(clk), .nRESET(nreset),
    .RREQ(rreq[1]), .RADDR(raddr[1]), .RACK(rack[1]), .RDATA(rdata[1]),
    .PREQ(preq[1]), .PADDR(paddr[1]), .PACK(pack[1]), .PDATA(pdata[1]),
    .ROM_A(rom_a[1]), .ROM_nOE(rom_noe[1]), .ROM_D(rom_d[1]), .BUSY(busy[1]));
  pcm_arbiter #(.ROM_WAIT(1)) u_dut2 (
    .CLK_68KCLKB(clk), .nRESET(nreset),
    .RREQ(rreq[2]), .RADDR(raddr[2]), .RACK(rack[2]), .RDATA(rdata[2]),
    .PREQ(preq[2]), .PADDR(paddr[2]), .PACK(pack[2]), .PDATA(pdata[2]),
    .ROM_A(rom_a[2]), .ROM_nOE(rom_noe[2]), .ROM_D(rom_d[2]), .BUSY(busy[2]));
  pcm_arbiter #(.ROM_WAIT(7)) u_dut3 (
    .CLK_68KCLKB(clk), .nRESET(nreset),
    .RREQ(rreq[3]), .RADDR(raddr[3]), .RACK(rack[3]), .RDATA(rdata[3]),
    .PREQ(preq[3]), .PADDR(paddr[3]), .PACK(pack[3]), .PDATA(pdata[3]),
    .ROM_A(rom_a[3]), .ROM_nOE(rom_noe[3]), .ROM_D(rom_d[3]), .BUSY(busy[3]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(int inst, logic port, logic [23:0] addr, int at);
    exp_t e;
    e.inst = inst;
    e.port = port;
    e.data = rom_fn(addr);
    e.cyc  = at;
    sbq.push_back(e);
  endtask

  task automatic check_ack(int inst, logic port, logic [7:0] data);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_ack: inst %0d port %0d data %h cycle %0d, no ACK required",
               inst, port, data, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.inst != inst || e.port !== port || e.data !== data || e.cyc != cyc) begin
        fails++;
        $display("FAIL ack_match: got inst %0d port %0d data %h cycle %0d, required inst %0d port %0d data %h cycle %0d",
                 inst, port, data, cyc, e.inst, e.port, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every ACK is matched against the scoreboard head.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rack[i] === 1'b1 || pack[i] === 1'b1) chk("ack_exclusive", {31'd0, rack[i] & pack[i]}, 32'd0);
      if (rack[i] === 1'b1) check_ack(i, PORT_A, rdata[i]);
      if (pack[i] === 1'b1) check_ack(i, PORT_B, pdata[i]);
      if (prev_noe[i] === 1'b0 && rom_noe[i] === 1'b0) chk("rom_a_stable", {8'd0, rom_a[i]}, {8'd0, prev_a[i]});
      prev_a[i]   = rom_a[i];
      prev_noe[i] = rom_noe[i];
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      rreq[i] = 1'b0; preq[i] = 1'b0; raddr[i] = '0; paddr[i] = '0;
    end
    tick(3);
    chk("rst_rom_a", {8'd0, rom_a[0]}, 32'd0);
    chk("rst_noe", {31'd0, rom_noe[0]}, 32'd1);
    chk("rst_rack", {31'd0, rack[0]}, 32'd0);
    chk("rst_pack", {31'd0, pack[0]}, 32'd0);
    chk("rst_rdata", {24'd0, rdata[0]}, 32'd0);
    chk("rst_pdata", {24'd0, pdata[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    nreset = 1'b1;
    tick(2);

    // Simultaneous requests held straight after reset.
    n = cyc;
    raddr[0] = 24'h000011; paddr[0] = 24'h000022;
    rreq[0] = 1'b1; preq[0] = 1'b1;
`ifdef PCM_ARB_PRIO_B_EN
    expect_ack(0, PORT_B, 24'h000022, n + 3);
    expect_ack(0, PORT_B, 24'h000022, n + 7);
    expect_ack(0, PORT_B, 24'h000022, n + 11);
    tick(11);
`else
    expect_ack(0, PORT_A, 24'h000011, n + 3);
    expect_ack(0, PORT_B, 24'h000022, n + 7);
    expect_ack(0, PORT_A, 24'h000011, n + 11);
    expect_ack(0, PORT_B, 24'h000022, n + 15);
    tick(15);
`endif
    rreq[0] = 1'b0; preq[0] = 1'b0;
    tick(3);

    // Single A request, ROM_WAIT=2.
    n = cyc;
    raddr[0] = 24'h123456; rreq[0] = 1'b1;
    expect_ack(0, PORT_A, 24'h123456, n + 3);
    tick(1);
    chk("single_rom_a", {8'd0, rom_a[0]}, 32'h00123456);
    chk("single_noe_c1", {31'd0, rom_noe[0]}, 32'd0);
    chk("single_busy", {31'd0, busy[0]}, 32'd1);
    tick(1);
    chk("single_noe_c2", {31'd0, rom_noe[0]}, 32'd0);
    tick(1);
    chk("single_noe_end", {31'd0, rom_noe[0]}, 32'd1);
    chk("single_rdata", {24'd0, rdata[0]}, 32'h000000A5);
    chk("single_pack", {31'd0, pack[0]}, 32'd0);
    chk("single_busy_done", {31'd0, busy[0]}, 32'd1);
    rreq[0] = 1'b0;
    tick(1);
    chk("single_busy_idle", {31'd0, busy[0]}, 32'd0);
    tick(2);

    // Late arrival of B during A's access.
    n = cyc;
    raddr[0] = 24'h0000AB; rreq[0] = 1'b1;
    expect_ack(0, PORT_A, 24'h0000AB, n + 3);
    expect_ack(0, PORT_B, 24'hABCDEF, n + 7);
    tick(1);
    paddr[0] = 24'hABCDEF; preq[0] = 1'b1;
    tick(1);
    chk("late_rom_a_hold", {8'd0, rom_a[0]}, 32'h000000AB);
    tick(1);
    rreq[0] = 1'b0;
    tick(2);
    chk("late_rom_a_b", {8'd0, rom_a[0]}, 32'h00ABCDEF);
    tick(2);
    preq[0] = 1'b0;
    chk("late_rdata_held", {24'd0, rdata[0]}, {24'd0, rom_fn(24'h0000AB)});
    tick(3);

    // A pulsed for one cycle while B is served: never granted.
    n = cyc;
    paddr[0] = 24'h000100; preq[0] = 1'b1;
    expect_ack(0, PORT_B, 24'h000100, n + 3);
    tick(1);
    raddr[0] = 24'h000300; rreq[0] = 1'b1;
    tick(1);
    rreq[0] = 1'b0;
    tick(1);
    preq[0] = 1'b0;
    tick(5);

    // One-cycle A request in IDLE still completes.
    n = cyc;
    raddr[0] = 24'h000200; rreq[0] = 1'b1;
    expect_ack(0, PORT_A, 24'h000200, n + 3);
    tick(1);
    rreq[0] = 1'b0;
    tick(6);

    // Reset on the second ACCESS cycle of a ROM_WAIT=3 instance.
    raddr[1] = 24'h0F0F0F; rreq[1] = 1'b1;
    tick(1);
    chk("rstmid_noe_low", {31'd0, rom_noe[1]}, 32'd0);
    tick(1);
    nreset = 1'b0; rreq[1] = 1'b0;
    tick(1);
    chk("rstmid_noe", {31'd0, rom_noe[1]}, 32'd1);
    chk("rstmid_rom_a", {8'd0, rom_a[1]}, 32'd0);
    chk("rstmid_busy", {31'd0, busy[1]}, 32'd0);
    chk("rstmid_rack", {31'd0, rack[1]}, 32'd0);
    chk("rstmid_rdata0", {24'd0, rdata[0]}, 32'd0);
    nreset = 1'b1;
    tick(6);

    // Latency sweep at ROM_WAIT=1 and ROM_WAIT=7.
    n = cyc;
    raddr[2] = 24'h654321; rreq[2] = 1'b1;
    expect_ack(2, PORT_A, 24'h654321, n + 2);
    tick(2);
    rreq[2] = 1'b0;
    tick(2);
    n = cyc;
    paddr[2] = 24'hFFFFFF; preq[2] = 1'b1;
    expect_ack(2, PORT_B, 24'hFFFFFF, n + 2);
    tick(2);
    preq[2] = 1'b0;
    tick(2);
    n = cyc;
    raddr[3] = 24'h800000; rreq[3] = 1'b1;
    expect_ack(3, PORT_A, 24'h800000, n + 8);
    tick(8);
    rreq[3] = 1'b0;
    tick(2);
    n = cyc;
    paddr[3] = 24'h7FFFFE; preq[3] = 1'b1;
    expect_ack(3, PORT_B, 24'h7FFFFE, n + 8);
    tick(8);
    preq[3] = 1'b0;
    chk("sweep_rom_a", {8'd0, rom_a[3]}, 32'h007FFFFE);
    tick(6);

    chk("sb_drain", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcm_arbiter.md
PCM_ARBITER -- requirements
Module: pcm_arbiter

Interface
REQ-001 Parameter: ROM_WAIT, default 2, ROM read cycles with ROM_nOE low before data capture; legal range 1..7.
REQ-002 CLK_68KCLKB  input  1  block clock; all state changes on rising edge.
REQ-003 nRESET  input  1  reset; synchronous and active-low.
REQ-004 RREQ  input  1  ADPCM-A port read request; held high until RACK.
REQ-005 RADDR  input  24  ADPCM-A byte address; stable while RREQ high.
REQ-006 RACK  output  1  ADPCM-A one-cycle completion pulse.
REQ-007 RDATA  output  8  ADPCM-A read data; valid with RACK, held until the next RACK.
REQ-008 PREQ  input  1  ADPCM-B port read request; same rules as RREQ.
REQ-009 PADDR  input  24  ADPCM-B byte address.
REQ-010 PACK  output  1  ADPCM-B one-cycle completion pulse.
REQ-011 PDATA  output  8  ADPCM-B read data; valid with PACK, held until the next PACK.
REQ-012 ROM_A  output  24  shared sample-ROM address.
REQ-013 ROM_nOE  output  1  shared ROM output enable, active low.
REQ-014 ROM_D  input  8  shared ROM data.
REQ-015 BUSY  output  1  high while a ROM access is in progress (ACCESS or DONE).

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; all outputs registered.
REQ-017 IDLE, no request: stay IDLE, ROM_nOE=1, ROM_A holds its last value.
REQ-018 IDLE, any request at edge k: grant one port, latch its address into ROM_A, ROM_nOE=0 from cycle k+1, load wait counter with ROM_WAIT-1, go ACCESS.
REQ-019 ACCESS: counter decrements each cycle; at counter 0, capture ROM_D into the granted port's data register, drive ROM_nOE=1, pulse that port's ACK for one cycle, go DONE.
REQ-020 DONE: always go IDLE next cycle; ACK low; no new grant in DONE.
REQ-021 Latency: request sampled at edge k -> ACK high in cycle k+ROM_WAIT+1; back-to-back service period is ROM_WAIT+2 cycles.
REQ-022 A requester whose REQ is still high in the cycle after its ACK is treated as a new request.
REQ-023 REQ dropped before grant: request ignored; REQ dropped after grant: the access completes and ACK is still issued.
REQ-024 Simultaneous RREQ and PREQ in IDLE: round-robin; grant the port not granted last; last_grant updates on every grant.
REQ-025 Single request: always granted regardless of last_grant.
REQ-026 ROM_A and ROM_nOE never change within ACCESS; ROM_A changes only on grant.
REQ-027 RACK and PACK never high in the same cycle.
REQ-028 Addresses pass through unmodified, 24 bits, with no wrap or offset arithmetic.

Reset
REQ-029 With nRESET low at a rising edge, the block enters IDLE. Reset values: ROM_A=0, ROM_nOE=1, RACK=0, PACK=0, RDATA=0, PDATA=0, BUSY=0, counter=0, last_grant=B (so A wins the first tie).
REQ-030 Reset during ACCESS or DONE aborts the access with no ACK; ROM_nOE=1 on the cycle after the reset edge.

Configuration
REQ-031 Macro PCM_ARB_PRIO_B_EN defined: on simultaneous requests, ADPCM-B is always granted and last_grant is ignored.
REQ-032 PCM_ARB_PRIO_B_EN undefined: round-robin per REQ-024.

Structure
REQ-033 Package pcm_pkg holds: the FSM state enum, port-id constants (PORT_A, PORT_B), the ROM_WAIT default, and address/data width constants (24, 8).
REQ-034 Sub-module pcm_rr_arb holds the two-way grant decision and last_grant register, including the PCM_ARB_PRIO_B_EN variant; the FSM, counter and data registers stay in pcm_arbiter.

Verification
REQ-035 Single A request: ROM_WAIT=2, RADDR=0x123456, ROM_D=0xA5 -> ROM_A=0x123456 with ROM_nOE low for 2 cycles, RACK in cycle k+3, RDATA=0xA5, PACK stays 0.
REQ-036 Simultaneous requests after reset: RREQ=PREQ=1 held -> service order A, B, A, B (round-robin); each ACK 4 cycles apart; with PCM_ARB_PRIO_B_EN -> B, B, B while PREQ is held.
REQ-037 Late arrival: PREQ rises during A's ACCESS -> no ROM_A change mid-access; B granted in the IDLE following DONE.
REQ-038 Reset mid-access: nRESET low on the 2nd ACCESS cycle (ROM_WAIT=3) -> no RACK, ROM_nOE=1 and all outputs at reset values on the next cycle.
REQ-039 Abandon: RREQ pulsed high 1 cycle while B is being served -> A is never granted and no RACK; a one-cycle RREQ in IDLE -> RACK still issued.
REQ-040 ROM_WAIT=1 and ROM_WAIT=7 sweep: ACK latency is exactly ROM_WAIT+1 cycles from request sampling.
